// File: rtl/tg2_csr_pkg.sv
// ---------------------------------------------------------------------------
// tg2_csr_pkg
// Shared definitions for the TG2 traffic-generator control slice:
//   - TG_START_ADDR    : TG2 config register that kicks off a test run
//   - seq_state_e      : run-sequencer FSM states
//   - tg2_tbl_entry_t  : one replay-table entry {TG2 register address, data}
//   - sat_inc16        : saturating 16-bit increment used by the run counters
// ---------------------------------------------------------------------------
package tg2_csr_pkg;

  localparam int TG2_ADDR_W = 14;
  localparam int TG2_DATA_W = 32;

  // TG2 start register; writing 1 launches a traffic run
  localparam logic [TG2_ADDR_W-1:0] TG_START_ADDR = 14'h0020;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    START,
    CLR,
    RUN,
    CHK
  } seq_state_e;

  typedef struct packed {
    logic [TG2_ADDR_W-1:0] addr;
    logic [TG2_DATA_W-1:0] data;
  } tg2_tbl_entry_t;

  // Run counters stick at all-ones instead of wrapping back to zero
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tg2_run_sequencer_tbl.sv
// ---------------------------------------------------------------------------
// tg2_seq_tbl
// Register-write replay table: TBL_DEPTH entries of tg2_tbl_entry_t.
// Ports:
//   clk      : memory user clock
//   we       : write strobe for entry wr_idx
//   wr_idx   : entry index to write
//   wr_entry : {address, data} to store
//   rd_idx   : entry index to read
//   rd_entry : combinational read data for rd_idx
// Contents are deliberately not reset; the host reloads them as needed.
// ---------------------------------------------------------------------------
module tg2_seq_tbl
  import tg2_csr_pkg::*;
#(
  parameter int TBL_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(TBL_DEPTH)-1:0] wr_idx,
  input  tg2_tbl_entry_t               wr_entry,
  input  logic [$clog2(TBL_DEPTH)-1:0] rd_idx,
  output tg2_tbl_entry_t               rd_entry
);

  tg2_tbl_entry_t mem [TBL_DEPTH];

  // Single write port; a write may land in any sequencer state, so an
  // update during a run only shows up on the next replay pass
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_entry;
    end
  end

  // Asynchronous read so the sequencer can drive the Avalon bus directly
  assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/tg2_run_sequencer.sv
// ---------------------------------------------------------------------------
// tg2_run_sequencer
// Replays a table of TG2 config writes over Avalon-MM, writes the start
// register, waits for pass/fail/timeout status and records per-run results,
// repeating for num_iter runs.
// Ports:
//   clk, rst                       : memory clock, synchronous active-high reset
//   tbl_we/tbl_idx/tbl_addr/tbl_data : replay-table write port
//   tbl_len                        : entries to replay (0 = start write only)
//   num_iter                       : runs per go (0 behaves as 1)
//   wd_limit                       : watchdog cycles per wait phase (0 = off)
//   go, abort                      : start pulse (IDLE only), return to IDLE
//   cfg_*                          : Avalon-MM master to the TG2 config port
//   tg_pass/tg_fail/tg_timeout     : TG2 status levels
//   busy, done                     : not-IDLE level, completion pulse
//   iter_cnt/pass_cnt/fail_cnt/tmo_cnt : saturating run counters
//   last_cycles                    : start-accept to completion, last run
//   wd_err                         : sticky watchdog trip, cleared on go
// An abort drops any in-flight cfg_write without waiting for waitrequest;
// that Avalon protocol violation is accepted so abort is always immediate.
// ---------------------------------------------------------------------------
module tg2_run_sequencer
  import tg2_csr_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int TBL_DEPTH = 16,
  parameter int WD_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tbl_we,
  input  logic [$clog2(TBL_DEPTH)-1:0] tbl_idx,
  input  logic [ADDR_W-1:0]            tbl_addr,
  input  logic [DATA_W-1:0]            tbl_data,
  input  logic [$clog2(TBL_DEPTH):0]   tbl_len,
  input  logic [15:0]                  num_iter,
  input  logic [WD_W-1:0]              wd_limit,
  input  logic                         go,
  input  logic                         abort,
  output logic [ADDR_W-1:0]            cfg_address,
  output logic                         cfg_write,
  output logic [DATA_W-1:0]            cfg_writedata,
  output logic                         cfg_read,
  input  logic                         cfg_waitrequest,
  input  logic                         tg_pass,
  input  logic                         tg_fail,
  input  logic                         tg_timeout,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  iter_cnt,
  output logic [15:0]                  pass_cnt,
  output logic [15:0]                  fail_cnt,
  output logic [15:0]                  tmo_cnt,
  output logic [63:0]                  last_cycles,
  output logic                         wd_err
);

  localparam int IDX_W = $clog2(TBL_DEPTH);
  localparam int LEN_W = IDX_W + 1;

  seq_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [63:0]    cyc_q;
  logic [WD_W-1:0] wd_q;
  tg2_tbl_entry_t wr_entry, rd_entry;

  logic run_init, idx_inc, idx_clr, cyc_clr, cyc_run, wd_clr;
  logic rec_pass, rec_fail, rec_tmo, wd_trip;
  logic status_any, wd_hit, last_entry;
  logic [15:0] iter_max;
  seq_state_e  first_state;

  assign wr_entry = '{addr: TG2_ADDR_W'(tbl_addr), data: TG2_DATA_W'(tbl_data)};

  tg2_seq_tbl #(.TBL_DEPTH(TBL_DEPTH)) u_tbl (
    .clk      (clk),
    .we       (tbl_we),
    .wr_idx   (tbl_idx),
    .wr_entry (wr_entry),
    .rd_idx   (idx_q),
    .rd_entry (rd_entry)
  );

  assign cfg_read    = 1'b0;
  assign busy        = (state_q != IDLE);
  assign status_any  = tg_pass | tg_fail | tg_timeout;
  assign wd_hit      = (wd_limit != '0) && (wd_q == wd_limit - WD_W'(1));
  assign last_entry  = (LEN_W'(idx_q) == tbl_len - LEN_W'(1));
  assign iter_max    = (num_iter == 16'd0) ? 16'd1 : num_iter;
  // An empty table skips straight to the start write
  assign first_state = (tbl_len == '0) ? START : WR;

  // State register; reset parks the FSM in IDLE, which drops cfg_write
  // on the cycle after rst
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, Avalon drive and datapath strobes. The watchdog only ever
  // guards the two status-wait phases; bus stalls in WR/START are left to
  // the host to notice. abort overrides everything at the end so counters
  // freeze and done never fires on an aborted sequence.
  always_comb begin
    state_d       = state_q;
    cfg_write     = 1'b0;
    cfg_address   = '0;
    cfg_writedata = '0;
    done          = 1'b0;
    run_init      = 1'b0;
    idx_inc       = 1'b0;
    idx_clr       = 1'b0;
    cyc_clr       = 1'b0;
    cyc_run       = 1'b0;
    wd_clr        = 1'b0;
    rec_pass      = 1'b0;
    rec_fail      = 1'b0;
    rec_tmo       = 1'b0;
    wd_trip       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          run_init = 1'b1;
          state_d  = first_state;
        end
      end
      WR: begin
        cfg_write     = 1'b1;
        cfg_address   = ADDR_W'(rd_entry.addr);
        cfg_writedata = DATA_W'(rd_entry.data);
        if (!cfg_waitrequest) begin
          if (last_entry) state_d = START;
          else            idx_inc = 1'b1;
        end
      end
      START: begin
        cfg_write     = 1'b1;
        cfg_address   = ADDR_W'(TG_START_ADDR);
        cfg_writedata = DATA_W'(1);
        if (!cfg_waitrequest) begin
          cyc_clr = 1'b1;
          wd_clr  = 1'b1;
          state_d = CLR;
        end
      end
      CLR: begin
        cyc_run = 1'b1;
        if (!status_any) begin
          wd_clr  = 1'b1;
          state_d = RUN;
        end else if (wd_hit) begin
          wd_trip = 1'b1;
          state_d = CHK;
        end
      end
      RUN: begin
        cyc_run = 1'b1;
        if (tg_fail) begin
          rec_fail = 1'b1;
          state_d  = CHK;
        end else if (tg_timeout) begin
          rec_tmo = 1'b1;
          state_d = CHK;
        end else if (tg_pass) begin
          rec_pass = 1'b1;
          state_d  = CHK;
        end else if (wd_hit) begin
          wd_trip = 1'b1;
          state_d = CHK;
        end
      end
      CHK: begin
        if (iter_cnt < iter_max) begin
          idx_clr = 1'b1;
          state_d = first_state;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d  = IDLE;
      done     = 1'b0;
      run_init = 1'b0;
      idx_inc  = 1'b0;
      idx_clr  = 1'b0;
      cyc_clr  = 1'b0;
      cyc_run  = 1'b0;
      wd_clr   = 1'b0;
      rec_pass = 1'b0;
      rec_fail = 1'b0;
      rec_tmo  = 1'b0;
      wd_trip  = 1'b0;
    end
  end

  // Datapath: table index, run cycle counter, watchdog and result counters.
  // A watchdog trip is booked as a timeout outcome but leaves last_cycles
  // alone, since no real completion was observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      cyc_q       <= '0;
      wd_q        <= '0;
      iter_cnt    <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      tmo_cnt     <= '0;
      last_cycles <= '0;
      wd_err      <= 1'b0;
    end else begin
      if (run_init || idx_clr) idx_q <= '0;
      else if (idx_inc)        idx_q <= idx_q + 1'b1;

      if (cyc_clr)      cyc_q <= '0;
      else if (cyc_run) cyc_q <= cyc_q + 64'd1;

      if (wd_clr)       wd_q <= '0;
      else if (cyc_run) wd_q <= wd_q + 1'b1;

      if (run_init) begin
        iter_cnt    <= '0;
        pass_cnt    <= '0;
        fail_cnt    <= '0;
        tmo_cnt     <= '0;
        last_cycles <= '0;
        wd_err      <= 1'b0;
      end else begin
        if (rec_pass || rec_fail || rec_tmo) last_cycles <= cyc_q;
        if (rec_pass || rec_fail || rec_tmo || wd_trip) iter_cnt <= sat_inc16(iter_cnt);
        if (rec_pass)            pass_cnt <= sat_inc16(pass_cnt);
        if (rec_fail)            fail_cnt <= sat_inc16(fail_cnt);
        if (rec_tmo || wd_trip)  tmo_cnt  <= sat_inc16(tmo_cnt);
        if (wd_trip)             wd_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tg2_run_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tg2_run_sequencer
// Scoreboard bench: stimulus pushes expected Avalon writes and expected
// end-of-sequence results into queues; a negedge monitor pops and compares
// on every accepted write and every done pulse.
// ---------------------------------------------------------------------------
module tb_tg2_run_sequencer;
  import tg2_csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst, tbl_we, go, abort;
  logic [3:0]  tbl_idx;
  logic [13:0] tbl_addr;
  logic [31:0] tbl_data;
  logic [4:0]  tbl_len;
  logic [15:0] num_iter;
  logic [31:0] wd_limit;
  logic [13:0] cfg_address;
  logic        cfg_write, cfg_read;
  logic [31:0] cfg_writedata;
  logic        cfg_waitrequest = 1'b0;
  logic        tg_pass, tg_fail, tg_timeout;
  logic        busy, done, wd_err;
  logic [15:0] iter_cnt, pass_cnt, fail_cnt, tmo_cnt;
  logic [63:0] last_cycles;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
    bit          is_start;
  } exp_wr_t;

  typedef struct {
    logic [15:0] iter, pass, fail, tmo;
    logic [63:0] last;
    logic        wd;
    bit          chk_last;
  } exp_done_t;

  exp_wr_t   exp_wr[$];
  exp_done_t exp_done[$];

  int checks = 0, failures = 0;
  int cyc = 0;
  int stall_n = 0;
  int hold_seen = 0;
  int starts_seen = 0, last_start_cyc = 0;
  int done_count = 0, last_done_cyc = 0;
  logic [13:0] held_addr;
  logic [31:0] held_data;

  logic [13:0] ent_addr [3];
  logic [31:0] ent_data [3];

  tg2_run_sequencer dut (
    .clk(clk), .rst(rst),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .tbl_len(tbl_len), .num_iter(num_iter), .wd_limit(wd_limit),
    .go(go), .abort(abort),
    .cfg_address(cfg_address), .cfg_write(cfg_write), .cfg_writedata(cfg_writedata),
    .cfg_read(cfg_read), .cfg_waitrequest(cfg_waitrequest),
    .tg_pass(tg_pass), .tg_fail(tg_fail), .tg_timeout(tg_timeout),
    .busy(busy), .done(done),
    .iter_cnt(iter_cnt), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .tmo_cnt(tmo_cnt),
    .last_cycles(last_cycles), .wd_err(wd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model: stall each new write for stall_n cycles, then accept
  always @(posedge clk) begin
    #1;
    cfg_waitrequest = cfg_write && (hold_seen < stall_n);
  end

  // Monitor: write scoreboard, hold-stability checks, done scoreboard
  always @(negedge clk) begin
    exp_wr_t   ew;
    exp_done_t ed;
    if (rst || !cfg_write) begin
      hold_seen = 0;
    end else if (cfg_waitrequest) begin
      if (hold_seen == 0) begin
        held_addr = cfg_address;
        held_data = cfg_writedata;
      end else begin
        checkOutput("hold_addr", cfg_address, held_addr);
        checkOutput("hold_data", cfg_writedata, held_data);
      end
      hold_seen++;
    end else begin
      checkOutput("hold_cycles", hold_seen, stall_n);
      if (exp_wr.size() == 0) begin
        checkOutput("wr_unexpected", exp_wr.size(), 1);
      end else begin
        ew = exp_wr.pop_front();
        checkOutput("wr_addr", cfg_address, ew.addr);
        checkOutput("wr_data", cfg_writedata, ew.data);
        if (ew.is_start) begin
          starts_seen++;
          last_start_cyc = cyc;
        end
      end
      hold_seen = 0;
    end
    if (done) begin
      done_count++;
      last_done_cyc = cyc;
      if (exp_done.size() == 0) begin
        checkOutput("done_unexpected", exp_done.size(), 1);
      end else begin
        ed = exp_done.pop_front();
        checkOutput("iter_cnt", iter_cnt, ed.iter);
        checkOutput("pass_cnt", pass_cnt, ed.pass);
        checkOutput("fail_cnt", fail_cnt, ed.fail);
        checkOutput("tmo_cnt", tmo_cnt, ed.tmo);
        checkOutput("wd_err", wd_err, ed.wd);
        if (ed.chk_last) checkOutput("last_cycles", last_cycles, ed.last);
      end
    end
  end

  task automatic applyStimulus(input int len, input int niter, input int wdlim, input int stall);
    @(posedge clk); #1;
    tbl_len  = 5'(len);
    num_iter = 16'(niter);
    wd_limit = 32'(wdlim);
    stall_n  = stall;
  endtask

  task automatic pushRun(input int len);
    exp_wr_t e;
    for (int i = 0; i < len; i++) begin
      e = '{addr: ent_addr[i], data: ent_data[i], is_start: 1'b0};
      exp_wr.push_back(e);
    end
    e = '{addr: TG_START_ADDR, data: 32'd1, is_start: 1'b1};
    exp_wr.push_back(e);
  endtask

  task automatic pushDone(input int it, input int p, input int f, input int t,
                          input int last, input bit wd, input bit chk_last);
    exp_done_t e;
    e = '{iter: 16'(it), pass: 16'(p), fail: 16'(f), tmo: 16'(t),
          last: 64'(last), wd: wd, chk_last: chk_last};
    exp_done.push_back(e);
  endtask

  task automatic pulseGo();
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
  endtask

  task automatic setStatus(input logic p, input logic f, input logic t);
    tg_pass = p; tg_fail = f; tg_timeout = t;
  endtask

  task automatic waitStart(input int target);
    int n = 0;
    while (starts_seen < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("start_count", starts_seen, target);
  endtask

  // Returns #1 after the k-th posedge following start-write acceptance
  task automatic waitK(input int k);
    while (cyc < last_start_cyc + 1 + k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitDone(input int target);
    int n = 0;
    while (done_count < target && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("done_count", done_count, target);
  endtask

  // Drop stale status 3 cycles after start, raise new status at cycle k;
  // last_cycles for that run is then exactly k
  task automatic driveRun(input int target, input int k, input logic p, input logic f, input logic t);
    waitStart(target);
    waitK(3);
    setStatus(1'b0, 1'b0, 1'b0);
    waitK(k);
    setStatus(p, f, t);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation time limit reached");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    ent_addr[0] = 14'h0010; ent_data[0] = 32'hA;
    ent_addr[1] = 14'h0014; ent_data[1] = 32'hB;
    ent_addr[2] = 14'h0018; ent_data[2] = 32'hC;
    rst = 1'b1; tbl_we = 1'b0; go = 1'b0; abort = 1'b0;
    tbl_idx = '0; tbl_addr = '0; tbl_data = '0;
    tbl_len = '0; num_iter = '0; wd_limit = '0;
    setStatus(1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cfg_write", cfg_write, 0);
    checkOutput("rst_iter", iter_cnt, 0);
    checkOutput("rst_last", last_cycles, 0);
    checkOutput("rst_wd_err", wd_err, 0);
    checkOutput("cfg_read", cfg_read, 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tbl_we = 1'b1; tbl_idx = 4'(i); tbl_addr = ent_addr[i]; tbl_data = ent_data[i];
    end
    @(posedge clk); #1 tbl_we = 1'b0;

    $display("[TB] test 1: 3 entries, one run, pass at 50");
    applyStimulus(3, 1, 0, 0);
    pushRun(3);
    pushDone(1, 1, 0, 0, 50, 1'b0, 1'b1);
    pulseGo();
    driveRun(1, 50, 1'b1, 1'b0, 1'b0);
    waitDone(1);

    $display("[TB] test 2: same with 3-cycle waitrequest on every write");
    applyStimulus(3, 1, 0, 3);
    pushRun(3);
    pushDone(1, 1, 0, 0, 50, 1'b0, 1'b1);
    pulseGo();
    driveRun(2, 50, 1'b1, 1'b0, 1'b0);
    waitDone(2);

    // run 2 raises fail+timeout (fail wins), run 3 timeout+pass (timeout wins)
    $display("[TB] test 3: three runs, pass / fail / timeout");
    applyStimulus(3, 3, 0, 0);
    pushRun(3); pushRun(3); pushRun(3);
    pushDone(3, 1, 1, 1, 40, 1'b0, 1'b1);
    pulseGo();
    driveRun(3, 20, 1'b1, 1'b0, 1'b0);
    driveRun(4, 30, 1'b0, 1'b1, 1'b1);
    driveRun(5, 40, 1'b1, 1'b0, 1'b1);
    waitDone(3);

    // status already low: CLR exits after 1 cycle, trip 100 cycles into RUN,
    // done visible at the negedge 102 posedges after start acceptance
    $display("[TB] test 4: watchdog 100 with no status");
    applyStimulus(3, 1, 100, 0);
    setStatus(1'b0, 1'b0, 1'b0);
    pushRun(3);
    pushDone(1, 0, 0, 1, 0, 1'b1, 1'b0);
    pulseGo();
    waitStart(6);
    waitDone(4);
    checkOutput("wd_latency", last_done_cyc - last_start_cyc, 102);

    $display("[TB] test 5: abort during run 2 of 4");
    applyStimulus(3, 4, 0, 0);
    pushRun(3); pushRun(3);
    pulseGo();
    @(negedge clk);
    checkOutput("go_clr_wd_err", wd_err, 0);
    checkOutput("go_clr_iter", iter_cnt, 0);
    checkOutput("go_clr_tmo", tmo_cnt, 0);
    checkOutput("go_busy", busy, 1);
    driveRun(7, 10, 1'b1, 1'b0, 1'b0);
    waitStart(8);
    waitK(3);
    setStatus(1'b0, 1'b0, 1'b0);
    waitK(15);
    abort = 1'b1;
    @(negedge clk);
    checkOutput("abort_cycle_busy", busy, 1);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_iter", iter_cnt, 1);
    checkOutput("abort_pass", pass_cnt, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("abort_no_done", done_count, 4);
    checkOutput("abort_wr_left", exp_wr.size(), 0);

    $display("[TB] test 6: empty table, num_iter 0, go while busy");
    applyStimulus(0, 0, 0, 0);
    pushRun(0);
    pushDone(1, 1, 0, 0, 12, 1'b0, 1'b1);
    pulseGo();
    @(negedge clk);
    checkOutput("go2_clr_iter", iter_cnt, 0);
    checkOutput("go2_clr_pass", pass_cnt, 0);
    waitStart(9);
    waitK(3);
    setStatus(1'b0, 1'b0, 1'b0);
    waitK(6);
    go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    waitK(12);
    setStatus(1'b1, 1'b0, 1'b0);
    waitDone(5);

    $display("[TB] test 7: go and abort together in IDLE");
    @(posedge clk); #1 go = 1'b1; abort = 1'b1;
    @(posedge clk); #1 go = 1'b0; abort = 1'b0;
    @(negedge clk);
    checkOutput("go_abort_busy", busy, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("final_wr_left", exp_wr.size(), 0);
    checkOutput("final_done_left", exp_done.size(), 0);
    checkOutput("final_done_count", done_count, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
